btn_debounce_multi: RTL and testbench

N-channel push-button conditioner for the board button inputs on gport_e. Each channel is synchronised, debounced, and edge-detected. Each channel also detects a long press, with optional auto-repeat. It sits between the raw gport_e button pins and application logic in spartan_top, and replaces ad-hoc single-button edge logic.

---
 rtl/btn_debounce_multi_pkg.sv | 15 +
 rtl/btn_debounce_ch.sv | 90 +++++++++
 rtl/btn_debounce_multi.sv | 41 ++++
 tb/tb_btn_debounce_multi.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_multi_pkg.sv
// btn_debounce_multi_pkg: long-press state encoding and 100 MHz default timings for the button conditioner
package btn_debounce_multi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    localparam int DEBOUNCE_CYC_DEF = 500000;
    localparam int DB_W_DEF         = 20;
    localparam int LONG_CYC_DEF     = 50000000;
    localparam int LONG_W_DEF       = 26;

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel with synchroniser, debounce, edge pulses and long-press detection
module btn_debounce_ch
    import btn_debounce_multi_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int DB_W         = DB_W_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF,
    parameter int LONG_W       = LONG_W_DEF,
    parameter int REPEAT_EN    = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam logic POL = (ACTIVE_LOW != 0);

    logic              sync1, sync2, s, toggle, rise, fall, long_nx;
    logic [DB_W-1:0]   db_cnt;
    logic [LONG_W-1:0] hold_cnt, hold_nx;
    state_t            state, state_nx;

    assign s      = sync2 ^ POL;
    assign toggle = (s != o_level) && (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
    assign rise   = toggle & ~o_level;
    assign fall   = toggle & o_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= POL;
            sync2     <= POL;
            db_cnt    <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            state     <= IDLE;
            hold_cnt  <= '0;
        end else begin
            sync1     <= i_btn;
            sync2     <= sync1;
            db_cnt    <= (s != o_level && !toggle) ? db_cnt + 1'b1 : '0;
            o_level   <= o_level ^ toggle;
            o_press   <= rise;
            o_release <= fall;
            o_long    <= long_nx;
            state     <= state_nx;
            hold_cnt  <= hold_nx;
        end
    end

    // a release always wins, so o_long can never coincide with the fall
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        long_nx  = 1'b0;
        case (state)
            IDLE: begin
                state_nx = rise ? HELD : IDLE;
                hold_nx  = '0;
            end
            HELD: begin
                if (fall) begin
                    state_nx = IDLE;
                    hold_nx  = '0;
                end else if (hold_cnt == LONG_W'(LONG_CYC - 1)) begin
                    long_nx  = 1'b1;
                    hold_nx  = '0;
                    state_nx = (REPEAT_EN != 0) ? HELD : LONG;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            LONG: begin
                state_nx = fall ? IDLE : LONG;
                hold_nx  = '0;
            end
            default: begin
                state_nx = IDLE;
                hold_nx  = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N independent button channels conditioned in parallel
module btn_debounce_multi
    import btn_debounce_multi_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int DB_W         = DB_W_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF,
    parameter int LONG_W       = LONG_W_DEF,
    parameter int REPEAT_EN    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce_ch #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .DB_W        (DB_W),
            .LONG_CYC    (LONG_CYC),
            .LONG_W      (LONG_W),
            .REPEAT_EN   (REPEAT_EN)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_btn    (i_btn[g]),
            .o_level  (o_level[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g]),
            .o_long   (o_long[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: directed checks of debounce, edge pulses, long press and reset behaviour
module tb_btn_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn = 3'b111;
    logic [2:0] lvl0, pr0, rl0, lg0, lvl1, pr1, rl1, lg1;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int busy_n = 0;
    int both_n = 0;
    int press_n [3] = '{0, 0, 0};
    int rel_n [3] = '{0, 0, 0};
    int last_press [3] = '{-1, -1, -1};
    int last_rel [3] = '{-1, -1, -1};
    int long0_n = 0;
    int long0_at = -1;
    int long1_n = 0;
    int long1_at [4] = '{-1, -1, -1, -1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_debounce_multi #(
        .N_CH(3), .ACTIVE_LOW(1), .DEBOUNCE_CYC(4), .DB_W(3),
        .LONG_CYC(10), .LONG_W(4), .REPEAT_EN(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .i_btn(btn),
        .o_level(lvl0), .o_press(pr0), .o_release(rl0), .o_long(lg0)
    );

    btn_debounce_multi #(
        .N_CH(3), .ACTIVE_LOW(1), .DEBOUNCE_CYC(4), .DB_W(3),
        .LONG_CYC(10), .LONG_W(4), .REPEAT_EN(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .i_btn(btn),
        .o_level(lvl1), .o_press(pr1), .o_release(rl1), .o_long(lg1)
    );

    always @(negedge clk) begin
        if (|{lvl0, pr0, rl0, lg0, lvl1, pr1, rl1, lg1}) busy_n++;
        if (|(pr0 & rl0) || |(pr1 & rl1)) both_n++;
        for (int i = 0; i < 3; i++) begin
            if (pr0[i]) begin press_n[i]++; last_press[i] = cyc; end
            if (rl0[i]) begin rel_n[i]++; last_rel[i] = cyc; end
        end
        if (lg0[0]) begin long0_n++; long0_at = cyc; end
        if (lg1[0]) begin
            if (long1_n < 4) long1_at[long1_n] = cyc;
            long1_n++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int c, r, t_rel, p0, p2, r0, r2, l0, l1;

    initial begin
        // reset held with idle pins, then released
        tick(20);
        check("rst_quiet_during", busy_n, 0);
        rst_n = 1'b1;
        tick(10);
        check("rst_quiet_after", busy_n, 0);
        check("rst_level", int'(lvl0), 0);

        // one-cycle glitch on pin 1
        btn[1] = 1'b0;
        tick(1);
        btn[1] = 1'b1;
        tick(12);
        check("glitch_press", press_n[1], 0);
        check("glitch_rel", rel_n[1], 0);
        check("glitch_quiet", busy_n, 0);

        // clean press and release on pin 0
        c = cyc;
        btn[0] = 1'b0;
        tick(8);
        check("t3_press_n", press_n[0], 1);
        check("t3_press_at", last_press[0], c + 6);
        check("t3_level", int'(lvl0), 1);
        check("t3_level_rep", int'(lvl1), 1);
        c = cyc;
        btn[0] = 1'b1;
        tick(8);
        check("t3_rel_n", rel_n[0], 1);
        check("t3_rel_at", last_rel[0], c + 6);
        check("t3_level_off", int'(lvl0), 0);
        check("t3_no_long", long0_n + long1_n, 0);

        // bounce on pin 2 before settling low
        btn[2] = 1'b0; tick(3);
        btn[2] = 1'b1; tick(1);
        btn[2] = 1'b0; tick(3);
        btn[2] = 1'b1; tick(1);
        c = cyc;
        btn[2] = 1'b0;
        tick(7);
        check("t4_press_n", press_n[2], 1);
        check("t4_press_at", last_press[2], c + 6);
        btn[2] = 1'b1;
        tick(8);
        check("t4_rel_n", rel_n[2], 1);
        check("t4_level_off", int'(lvl0), 0);

        // long press on pin 0, held 35 cycles past the rise
        c = cyc;
        btn[0] = 1'b0;
        tick(35);
        t_rel = cyc;
        btn[0] = 1'b1;
        tick(8);
        check("t5_press_at", last_press[0], c + 6);
        check("t5_long_once_n", long0_n, 1);
        check("t5_long_once_at", long0_at, c + 16);
        check("t5_long_rep_n", long1_n, 3);
        check("t5_long_rep_at0", long1_at[0], c + 16);
        check("t5_long_rep_at1", long1_at[1], c + 26);
        check("t5_long_rep_at2", long1_at[2], c + 36);
        check("t5_rel_n", rel_n[0], 2);
        check("t5_rel_at", last_rel[0], t_rel + 6);

        // simultaneous press on 0 and 2, then reset while held
        c = cyc;
        btn = 3'b010;
        tick(8);
        check("t6_press0_at", last_press[0], c + 6);
        check("t6_press2_at", last_press[2], c + 6);
        check("t6_level", int'(lvl0), 5);
        p0 = press_n[0]; p2 = press_n[2]; r0 = rel_n[0]; r2 = rel_n[2];
        l0 = long0_n; l1 = long1_n;
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_level", int'(lvl0), 0);
        check("t6_rst_level_rep", int'(lvl1), 0);
        tick(1);
        r = cyc;
        rst_n = 1'b1;
        tick(8);
        check("t6_no_rel", (rel_n[0] - r0) + (rel_n[2] - r2), 0);
        check("t6_repress0_n", press_n[0] - p0, 1);
        check("t6_repress2_n", press_n[2] - p2, 1);
        check("t6_repress0_at", last_press[0], r + 6);
        check("t6_repress2_at", last_press[2], r + 6);
        check("t6_no_long", (long0_n - l0) + (long1_n - l1), 0);
        check("t6_level_back", int'(lvl0), 5);
        btn = 3'b111;
        tick(8);
        check("t6_rel0_n", rel_n[0] - r0, 1);
        check("t6_rel2_n", rel_n[2] - r2, 1);

        check("never_both", both_n, 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
